// File: rtl/pulse_generator.sv
// pulse_generator: four-channel 50 % duty square-wave generator.
// Each channel converts a frequency in Hz into a half-period cycle count
// using one shared 32-cycle restoring divider, then toggles its output
// every half period. Retunes take effect on a toggle boundary, so the
// output never glitches.
//
// Optional feature macro: PULSE_GEN_FREQ_CLAMP_EN
//   defined   - nonzero requests above F_MAX are divided as F_MAX
//   undefined - the raw request is divided
//
// Divider FSM states:
//   state  | meaning
//   S_IDLE | waiting for a pending channel; grants the highest-priority one
//   S_DIV  | 32 restoring-division steps computing CLK_FREQ / (2*freq)
//   S_WB   | writes the half-period into the granted channel's shadow register

module pulse_generator #(
  parameter int unsigned CLK_FREQ = 20_000_000,
  parameter int unsigned F_MAX    = 200_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] freq_in_0,
  input  logic [31:0] freq_in_1,
  input  logic [31:0] freq_in_2,
  input  logic [31:0] freq_in_3,
  input  logic [3:0]  freq_wr,
  output logic        busy,
  output logic        pulse_out_0,
  output logic        pulse_out_1,
  output logic        pulse_out_2,
  output logic        pulse_out_3
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  logic [31:0] freq_in [4];
  logic [31:0] req_val [4];
  logic [3:0]  pending;

  state_t      state;
  logic [1:0]  cur_ch;
  logic [31:0] quo;
  logic [32:0] rem;
  logic [32:0] divisor;
  logic [4:0]  bit_cnt;
  logic        zero_div;

  logic [1:0]  grant_ch;
  logic [31:0] grant_freq;
  logic [31:0] div_freq;

  logic [33:0] rem_shift;
  logic [32:0] rem_diff;
  logic        q_bit;
  logic [32:0] rem_next;

  logic        wb_vld;
  logic [31:0] wb_half;

  logic [31:0] half_cur [4];
  logic [31:0] half_nxt [4];
  logic [31:0] cnt      [4];
  logic [3:0]  upd;
  logic [3:0]  pulse;

  assign freq_in[0] = freq_in_0;
  assign freq_in[1] = freq_in_1;
  assign freq_in[2] = freq_in_2;
  assign freq_in[3] = freq_in_3;

  assign pulse_out_0 = pulse[0];
  assign pulse_out_1 = pulse[1];
  assign pulse_out_2 = pulse[2];
  assign pulse_out_3 = pulse[3];

  assign busy = (|pending) || (state != S_IDLE);

  // Fixed-priority arbiter: lowest channel index wins.
  always_comb begin
    grant_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) grant_ch = 2'(i);
    end
  end

  // Select the granted request and optionally clamp it to F_MAX.
  always_comb begin
    grant_freq = req_val[grant_ch];
    div_freq   = grant_freq;
`ifdef PULSE_GEN_FREQ_CLAMP_EN
    if (grant_freq > 32'(F_MAX)) div_freq = 32'(F_MAX);
`else
    div_freq   = grant_freq;
`endif
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem, quo[31]};
    q_bit     = (rem_shift >= {1'b0, divisor});
    rem_diff  = rem_shift[32:0] - divisor;
    rem_next  = q_bit ? rem_diff : rem_shift[32:0];
  end

  // A zero divisor would yield all-ones; force the result to zero instead.
  assign wb_vld  = (state == S_WB);
  assign wb_half = zero_div ? 32'd0 : quo;

  // Request capture, arbitration and the divider FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pending  <= '0;
      cur_ch   <= 2'd0;
      quo      <= '0;
      rem      <= '0;
      divisor  <= '0;
      bit_cnt  <= '0;
      zero_div <= 1'b0;
      for (int i = 0; i < 4; i++) req_val[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|pending) begin
            cur_ch            <= grant_ch;
            pending[grant_ch] <= 1'b0;
            divisor           <= {div_freq, 1'b0};
            zero_div          <= (div_freq == 32'd0);
            quo               <= 32'(CLK_FREQ);
            rem               <= '0;
            bit_cnt           <= '0;
            state             <= S_DIV;
          end
        end
        S_DIV: begin
          rem     <= rem_next;
          quo     <= {quo[30:0], q_bit};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) state <= S_WB;
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      // A new write re-arms the channel even if it was just granted.
      for (int i = 0; i < 4; i++) begin
        if (freq_wr[i]) begin
          req_val[i] <= freq_in[i];
          pending[i] <= 1'b1;
        end
      end
    end
  end

  // Per-channel half-period counters with boundary-aligned retune.
  always_ff @(posedge clk) begin
    if (rst) begin
      upd   <= '0;
      pulse <= '0;
      for (int i = 0; i < 4; i++) begin
        half_cur[i] <= '0;
        half_nxt[i] <= '0;
        cnt[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (half_cur[i] == 32'd0) begin
          pulse[i] <= 1'b0;
          cnt[i]   <= '0;
          if (upd[i]) begin
            half_cur[i] <= half_nxt[i];
            upd[i]      <= 1'b0;
          end
        end else if (cnt[i] == half_cur[i] - 32'd1) begin
          pulse[i] <= ~pulse[i];
          cnt[i]   <= '0;
          if (upd[i]) begin
            half_cur[i] <= half_nxt[i];
            upd[i]      <= 1'b0;
          end
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end
        // Writeback: zero switches the channel off at once, nonzero waits for a boundary.
        if (wb_vld && (cur_ch == 2'(i))) begin
          half_nxt[i] <= wb_half;
          if (wb_half == 32'd0) begin
            half_cur[i] <= '0;
            cnt[i]      <= '0;
            pulse[i]    <= 1'b0;
            upd[i]      <= 1'b0;
          end else begin
            upd[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: table of single-channel requests plus
// hand-written sequences for reset, retune/disable and simultaneous writes.
module tb_pulse_generator;

`ifdef PULSE_GEN_FREQ_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fin [4];
  logic [3:0]  freq_wr;
  logic        busy;
  logic        p0, p1, p2, p3;
  logic [3:0]  pls;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign pls = {p3, p2, p1, p0};

  pulse_generator #(
    .CLK_FREQ (20_000_000),
    .F_MAX    (200_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freq_in_0   (fin[0]),
    .freq_in_1   (fin[1]),
    .freq_in_2   (fin[2]),
    .freq_in_3   (fin[3]),
    .freq_wr     (freq_wr),
    .busy        (busy),
    .pulse_out_0 (p0),
    .pulse_out_1 (p1),
    .pulse_out_2 (p2),
    .pulse_out_3 (p3)
  );

  typedef struct {
    int          ch;
    logic [31:0] freq;
    int          half;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns just after the sampling edge.
  task automatic write_ch(input int ch, input logic [31:0] f);
    fin[ch] = f;
    freq_wr = 4'b0001 << ch;
    @(negedge clk);
    freq_wr = 4'b0000;
  endtask

  task automatic wait_busy(input string name);
    int k;
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, k, 34);
  endtask

  task automatic wait_level(input int ch, input logic lvl, input int limit, output int k);
    k = 0;
    while (pls[ch] != lvl && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int k;
    int j;
    int t;
    int busy_fall;
    int fall3;
    int act;
    int rise [4];

    vecs[0]  = '{1, 32'd1000,      10000};
    vecs[1]  = '{0, 32'd200000,    50};
    vecs[2]  = '{3, 32'd1000000,   CLAMP ? 50 : 10};
    vecs[3]  = '{2, 32'd15000000,  CLAMP ? 50 : 0};
    vecs[4]  = '{0, 32'd0,         0};
    vecs[5]  = '{1, 32'd3000000,   CLAMP ? 50 : 3};
    vecs[6]  = '{2, 32'd10000000,  CLAMP ? 50 : 1};
    vecs[7]  = '{3, 32'd100000,    100};
    vecs[8]  = '{0, 32'd10000001,  CLAMP ? 50 : 0};
    vecs[9]  = '{2, 32'd6667,      1499};
    vecs[10] = '{3, 32'd400000,    CLAMP ? 50 : 25};

    rst     = 1'b1;
    freq_wr = 4'b0000;
    for (int i = 0; i < 4; i++) fin[i] = 32'd0;

    // Reset held four cycles: everything quiet.
    repeat (4) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_pulses", pls, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    // Table: switch the channel off, request a frequency, time the first edges.
    for (int v = 0; v < 11; v++) begin
      write_ch(vecs[v].ch, 32'd0);
      wait_busy($sformatf("v%0d_off_busy", v));
      write_ch(vecs[v].ch, vecs[v].freq);
      wait_busy($sformatf("v%0d_busy_len", v));
      if (vecs[v].half == 0) begin
        wait_level(vecs[v].ch, 1'b1, 100, k);
        check($sformatf("v%0d_stays_low", v), k, 100);
      end else begin
        wait_level(vecs[v].ch, 1'b1, vecs[v].half + 50, k);
        check($sformatf("v%0d_first_rise", v), k, vecs[v].half + 1);
        wait_level(vecs[v].ch, 1'b0, vecs[v].half + 50, k);
        check($sformatf("v%0d_high_phase", v), k, vecs[v].half);
        wait_level(vecs[v].ch, 1'b1, vecs[v].half + 50, k);
        check($sformatf("v%0d_low_phase", v), k, vecs[v].half);
      end
    end

    // Reset during DIV: no writeback may follow.
    write_ch(1, 32'd1000);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_div_reset_busy", busy, 0);
    act = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy || (pls != 4'b0000)) act++;
    end
    check("mid_div_reset_quiet", act, 0);

    // Retune ch2 from 10 kHz to 20 kHz in the middle of a high phase.
    write_ch(2, 32'd10000);
    wait_busy("retune_busy_a");
    wait_level(2, 1'b1, 1100, k);
    check("retune_first_rise", k, 1001);
    j = 0;
    while (pls[2] && j < 3000) begin
      if (j == 300) begin
        fin[2]  = 32'd20000;
        freq_wr = 4'b0100;
      end else begin
        freq_wr = 4'b0000;
      end
      @(negedge clk);
      j++;
    end
    freq_wr = 4'b0000;
    check("retune_old_phase", j, 1000);
    wait_level(2, 1'b1, 600, k);
    check("retune_new_low", k, 500);
    wait_level(2, 1'b0, 600, k);
    check("retune_new_high", k, 500);
    wait_level(2, 1'b1, 600, k);
    check("retune_new_low2", k, 500);

    // Disable at the start of a high phase: low right after WB.
    write_ch(2, 32'd0);
    repeat (33) @(negedge clk);
    check("disable_high_before_wb", pls[2], 1);
    check("disable_busy_before_wb", busy, 1);
    @(negedge clk);
    check("disable_busy_after_wb", busy, 0);
    check("disable_low_after_wb", pls[2], 0);
    wait_level(2, 1'b1, 1100, k);
    check("disable_stays_low", k, 1100);

    // Four simultaneous writes: writebacks at 34/68/102/136.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fin[0]  = 32'd100;
    fin[1]  = 32'd1000;
    fin[2]  = 32'd10000;
    fin[3]  = 32'd100000;
    freq_wr = 4'b1111;
    @(negedge clk);
    freq_wr = 4'b0000;
    busy_fall = -1;
    fall3     = -1;
    for (int i = 0; i < 4; i++) rise[i] = -1;
    t = 0;
    while (t < 10100) begin
      @(negedge clk);
      t++;
      if (!busy && busy_fall < 0) busy_fall = t;
      for (int i = 0; i < 4; i++) begin
        if (pls[i] && rise[i] < 0) rise[i] = t;
      end
      if (!pls[3] && rise[3] >= 0 && fall3 < 0) fall3 = t;
    end
    check("simul_busy_fall", busy_fall, 136);
    check("simul_ch3_rise", rise[3], 237);
    check("simul_ch3_fall", fall3, 337);
    check("simul_ch2_rise", rise[2], 1103);
    check("simul_ch1_rise", rise[1], 10069);
    check("simul_ch0_still_low", rise[0], -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
